// File: rtl/uart_tx_if.sv
`default_nettype none
// ============================================================================
// uart_tx_if : byte-write handshake and line status for uart_tx
// Revision   : 1.0
// ============================================================================
interface uart_tx_if #(
  parameter int FIFO_DEPTH = 4
);
  logic                        i_Tx_DV;
  logic [7:0]                  i_Tx_Byte;
  logic                        o_Tx_Ready;
  logic                        o_Tx_Serial;
  logic                        o_Tx_Active;
  logic                        o_Tx_Done;
  logic [$clog2(FIFO_DEPTH):0] o_Fifo_Count;

  modport slave (
    input  i_Tx_DV, i_Tx_Byte,
    output o_Tx_Ready, o_Tx_Serial, o_Tx_Active, o_Tx_Done, o_Fifo_Count
  );

  modport master (
    output i_Tx_DV, i_Tx_Byte,
    input  o_Tx_Ready, o_Tx_Serial, o_Tx_Active, o_Tx_Done, o_Fifo_Count
  );
endinterface
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// uart_tx  : 8N1 UART transmitter with input FIFO, gapless back-to-back frames
// Revision : 1.0
// ============================================================================
module uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 4,
  parameter int STOP_BITS    = 1
) (
  input wire        i_Clock,
  input wire        i_Reset_n,
  uart_tx_if.slave  tx_bus
);

  localparam int c_CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int c_PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  localparam logic [c_CNT_W-1:0] c_CLK_LAST = c_CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [c_CNT_W-1:0] c_CLK_ONE  = c_CNT_W'(1);
  localparam logic [c_PTR_W-1:0] c_PTR_ONE  = c_PTR_W'(1);
  localparam logic [c_PTR_W:0]   c_CNT_ONE  = (c_PTR_W + 1)'(1);
  localparam logic [c_PTR_W:0]   c_FULL     = (c_PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [2:0]         c_STOP_LAST = 3'(STOP_BITS - 1);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_START = 2'd1;
  localparam logic [1:0] c_DATA  = 2'd2;
  localparam logic [1:0] c_STOP  = 2'd3;

  logic [1:0]         r_state;
  logic [c_CNT_W-1:0] r_clk_cnt;
  logic [2:0]         r_bit_idx;
  logic [7:0]         r_shift;
  logic               r_serial;
  logic               r_active;
  logic               r_done;
  logic [7:0]         r_mem [FIFO_DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_PTR_W:0]   r_count;

  logic [1:0]         w_state_nxt;
  logic [c_CNT_W-1:0] w_clk_cnt_nxt;
  logic [2:0]         w_bit_idx_nxt;
  logic               w_serial_nxt;
  logic               w_active_nxt;
  logic               w_done_nxt;
  logic               w_pop;
  logic               w_wr;
  logic               w_empty;
  logic               w_full;
  logic               w_bit_end;

  // Ready is a function of the count alone, so a pop on a full cycle cannot admit a write.
  assign w_full    = (r_count == c_FULL);
  assign w_empty   = (r_count == '0);
  assign w_wr      = tx_bus.i_Tx_DV & ~w_full;
  assign w_bit_end = (r_clk_cnt == c_CLK_LAST);

  assign tx_bus.o_Tx_Ready   = ~w_full;
  assign tx_bus.o_Tx_Serial  = r_serial;
  assign tx_bus.o_Tx_Active  = r_active;
  assign tx_bus.o_Tx_Done    = r_done;
  assign tx_bus.o_Fifo_Count = r_count;

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      r_state   <= c_IDLE;
      r_clk_cnt <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_serial  <= 1'b1;
      r_active  <= 1'b0;
      r_done    <= 1'b0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clk_cnt <= w_clk_cnt_nxt;
      r_bit_idx <= w_bit_idx_nxt;
      r_serial  <= w_serial_nxt;
      r_active  <= w_active_nxt;
      r_done    <= w_done_nxt;
      if (w_pop) begin
        r_shift  <= r_mem[r_rd_ptr];
        r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      end
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      end
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + c_CNT_ONE;
        2'b01:   r_count <= r_count - c_CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_Clock) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= tx_bus.i_Tx_Byte;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE:  if (!w_empty) w_state_nxt = c_START;
      c_START: if (w_bit_end) w_state_nxt = c_DATA;
      c_DATA:  if (w_bit_end && (r_bit_idx == 3'd7)) w_state_nxt = c_STOP;
      c_STOP:  if (w_bit_end && (r_bit_idx == c_STOP_LAST))
                 w_state_nxt = w_empty ? c_IDLE : c_START;
      default: w_state_nxt = c_IDLE;
    endcase
  end

  always_comb begin
    w_pop         = 1'b0;
    w_serial_nxt  = r_serial;
    w_active_nxt  = r_active;
    w_done_nxt    = 1'b0;
    w_clk_cnt_nxt = w_bit_end ? '0 : (r_clk_cnt + c_CLK_ONE);
    w_bit_idx_nxt = r_bit_idx;
    case (r_state)
      c_IDLE: begin
        w_clk_cnt_nxt = '0;
        w_bit_idx_nxt = '0;
        w_serial_nxt  = 1'b1;
        w_active_nxt  = 1'b0;
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_serial_nxt = 1'b0;
          w_active_nxt = 1'b1;
        end
      end
      c_START: begin
        if (w_bit_end) begin
          w_serial_nxt  = r_shift[0];
          w_bit_idx_nxt = '0;
        end
      end
      c_DATA: begin
        if (w_bit_end) begin
          if (r_bit_idx == 3'd7) begin
            w_serial_nxt  = 1'b1;
            w_bit_idx_nxt = '0;
          end else begin
            w_serial_nxt  = r_shift[r_bit_idx + 3'd1];
            w_bit_idx_nxt = r_bit_idx + 3'd1;
          end
        end
      end
      c_STOP: begin
        // r_bit_idx counts stop bits here; the last one ends the frame.
        if (w_bit_end) begin
          if (r_bit_idx == c_STOP_LAST) begin
            w_done_nxt    = 1'b1;
            w_bit_idx_nxt = '0;
            if (!w_empty) begin
              w_pop        = 1'b1;
              w_serial_nxt = 1'b0;
            end else begin
              w_serial_nxt = 1'b1;
              w_active_nxt = 1'b0;
            end
          end else begin
            w_bit_idx_nxt = r_bit_idx + 3'd1;
          end
        end
      end
      default: begin
        w_serial_nxt  = 1'b1;
        w_active_nxt  = 1'b0;
        w_clk_cnt_nxt = '0;
        w_bit_idx_nxt = '0;
      end
    endcase
  end

endmodule
`default_nettype wire
